// File: rtl/twofish_pkg.sv
// Shared Twofish definitions for the round engine and its F-function.
//   BLK_W / WORD_W : block and word widths
//   state_e        : round-engine FSM states
//   rol1 / ror1    : 1-bit 32-bit rotates used by the Feistel round
//   rol8           : byte rotate applied to R1 before its g-function
package twofish_pkg;

   localparam int unsigned BLK_W  = 128;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   function automatic logic [WORD_W-1:0] rol1(input logic [WORD_W-1:0] x);
      return {x[WORD_W-2:0], x[WORD_W-1]};
   endfunction

   function automatic logic [WORD_W-1:0] ror1(input logic [WORD_W-1:0] x);
      return {x[0], x[WORD_W-1:1]};
   endfunction

   function automatic logic [WORD_W-1:0] rol8(input logic [WORD_W-1:0] x);
      return {x[WORD_W-9:0], x[WORD_W-1:WORD_W-8]};
   endfunction

endpackage

// File: rtl/twofish_round_engine_f.sv
// Combinational Twofish F-function for a 128-bit key (two S-box words).
//   r0, r1 : left half of the round state
//   k0, k1 : round-key pair added after the PHT
//   s0, s1 : key-dependent S-box words; s0 feeds the inner q stage, s1 the outer
//   f0, f1 : F outputs (T0+T1+k0, T0+2*T1+k1, mod 2^32)
module twofish_round_engine_f
   import twofish_pkg::*;
(
   input  logic [WORD_W-1:0] r0,
   input  logic [WORD_W-1:0] r1,
   input  logic [WORD_W-1:0] k0,
   input  logic [WORD_W-1:0] k1,
   input  logic [WORD_W-1:0] s0,
   input  logic [WORD_W-1:0] s1,
   output logic [WORD_W-1:0] f0,
   output logic [WORD_W-1:0] f1
);

   // q-permutation nibble tables, entry i at bits [4i+3:4i]
   localparam logic [63:0] Q0_T0 = 64'h4ACE_95B0_23F6_D718;
   localparam logic [63:0] Q0_T1 = 64'hD907_6A4F_5321_8BCE;
   localparam logic [63:0] Q0_T2 = 64'h1742_3F8C_09D6_E5AB;
   localparam logic [63:0] Q0_T3 = 64'hAC58_03B9_E621_4F7D;
   localparam logic [63:0] Q1_T0 = 64'h5CA0_4913_E67F_DB82;
   localparam logic [63:0] Q1_T1 = 64'h809F_5AD6_73C4_B2E1;
   localparam logic [63:0] Q1_T2 = 64'hF3B2_8DE0_A961_57C4;
   localparam logic [63:0] Q1_T3 = 64'hA802_F746_ED3C_159B;

   // Per-byte q selection for the three h-function stages (bit j set = q1)
   localparam logic [3:0] SEL_IN  = 4'b1010;
   localparam logic [3:0] SEL_MID = 4'b1100;
   localparam logic [3:0] SEL_OUT = 4'b0101;

   // MDS matrix, row-major
   localparam logic [0:15][7:0] MDS = {8'h01, 8'hEF, 8'h5B, 8'h5B,
                                       8'h5B, 8'hEF, 8'hEF, 8'h01,
                                       8'hEF, 8'h5B, 8'h01, 8'hEF,
                                       8'hEF, 8'h01, 8'hEF, 8'h5B};

   function automatic logic [3:0] nib(input logic [63:0] tbl, input logic [3:0] idx);
      return tbl[{idx, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] ror4(input logic [3:0] x);
      return {x[0], x[3:1]};
   endfunction

   function automatic logic [7:0] q_perm(input logic [7:0] x, input logic use_q1);
      logic [63:0] t0, t1, t2, t3;
      logic [3:0]  a0, b0, a1, b1, a2, b2, a3, b3;
      t0 = use_q1 ? Q1_T0 : Q0_T0;
      t1 = use_q1 ? Q1_T1 : Q0_T1;
      t2 = use_q1 ? Q1_T2 : Q0_T2;
      t3 = use_q1 ? Q1_T3 : Q0_T3;
      a0 = x[7:4];
      b0 = x[3:0];
      a1 = a0 ^ b0;
      b1 = a0 ^ ror4(b0) ^ {a0[0], 3'b000};
      a2 = nib(t0, a1);
      b2 = nib(t1, b1);
      a3 = a2 ^ b2;
      b3 = a2 ^ ror4(b2) ^ {a2[0], 3'b000};
      return {nib(t3, b3), nib(t2, a3)};
   endfunction

   // GF(2^8) multiply modulo x^8+x^6+x^5+x^3+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc, x;
      acc = '0;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc ^= x;
         x = x[7] ? ((x << 1) ^ 8'h69) : (x << 1);
      end
      return acc;
   endfunction

   function automatic logic [WORD_W-1:0] g_func(input logic [WORD_W-1:0] x,
                                                input logic [WORD_W-1:0] sa,
                                                input logic [WORD_W-1:0] sb);
      logic [7:0] y [4];
      logic [7:0] z [4];
      for (int j = 0; j < 4; j++) begin
         y[j] = q_perm(q_perm(q_perm(x[8*j +: 8], SEL_IN[j]) ^ sa[8*j +: 8], SEL_MID[j])
                       ^ sb[8*j +: 8], SEL_OUT[j]);
      end
      for (int i = 0; i < 4; i++) begin
         z[i] = '0;
         for (int j = 0; j < 4; j++) z[i] ^= gf_mul(y[j], MDS[4*i+j]);
      end
      return {z[3], z[2], z[1], z[0]};
   endfunction

   logic [WORD_W-1:0] t0, t1;

   always_comb begin
      t0 = g_func(r0, s0, s1);
      t1 = g_func(rol8(r1), s0, s1);
      // PHT folded with the key add
      f0 = t0 + t1 + k0;
      f1 = t0 + {t1[WORD_W-2:0], 1'b0} + k1;
   end

endmodule

// File: rtl/twofish_round_engine.sv
// Iterative Twofish round core: one Feistel round per clock, ROUNDS rounds per block.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : block input handshake; in_decrypt and in_block sampled at accept
//   K0, K1                : round-key pair for rk_round, looked up combinationally upstream
//   S0, S1                : key-dependent S-box words, held stable while busy
//   rk_round              : round-key index needed this cycle (0 outside RUN)
//   busy                  : engine holds a block
//   out_valid/out_ready   : result handshake; out_block is 0 while out_valid is low
module twofish_round_engine
   import twofish_pkg::*;
#(
   parameter int unsigned  ROUNDS         = 16,
   parameter bit           UNDO_LAST_SWAP = 1'b1,
   localparam int unsigned RK_W           = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_decrypt,
   input  logic [BLK_W-1:0]  in_block,
   input  logic [WORD_W-1:0] K0,
   input  logic [WORD_W-1:0] K1,
   input  logic [WORD_W-1:0] S0,
   input  logic [WORD_W-1:0] S1,
   output logic [RK_W-1:0]   rk_round,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BLK_W-1:0]  out_block
);

   localparam int unsigned      CNT_W    = $clog2(ROUNDS + 1);
   localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  rnd_q;
   logic              mode_q;
   logic              out_valid_q;
   logic [WORD_W-1:0] r0_q, r1_q, r2_q, r3_q;

   logic [WORD_W-1:0] f0, f1, n2, n3;
   logic [CNT_W-1:0]  rk_full;
   logic              load;

   twofish_round_engine_f u_f (
      .r0 (r0_q),
      .r1 (r1_q),
      .k0 (K0),
      .k1 (K1),
      .s0 (S0),
      .s1 (S1),
      .f0 (f0),
      .f1 (f1)
   );

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign load      = in_valid && in_ready;
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;

   always_comb begin
      if (mode_q) begin
         n2 = rol1(r2_q) ^ f0;
         n3 = ror1(r3_q ^ f1);
      end else begin
         n2 = ror1(r2_q ^ f0);
         n3 = rol1(r3_q) ^ f1;
      end
   end

   // Decrypt walks the key schedule backwards
   always_comb begin
      rk_full  = mode_q ? (LAST_RND - rnd_q) : rnd_q;
      rk_round = (state_q == RUN) ? RK_W'(rk_full) : '0;
   end

   always_comb begin
      out_block = '0;
      if (out_valid_q) begin
         out_block = UNDO_LAST_SWAP ? {r2_q, r3_q, r0_q, r1_q} : {r0_q, r1_q, r2_q, r3_q};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rnd_q       <= '0;
         mode_q      <= 1'b0;
         out_valid_q <= 1'b0;
         r0_q        <= '0;
         r1_q        <= '0;
         r2_q        <= '0;
         r3_q        <= '0;
      end else if (load) begin
         // Covers both IDLE accept and back-to-back accept out of DONE
         {r0_q, r1_q, r2_q, r3_q} <= in_block;
         mode_q      <= in_decrypt;
         rnd_q       <= '0;
         out_valid_q <= 1'b0;
         state_q     <= RUN;
      end else begin
         unique case (state_q)
            IDLE: ;
            RUN: begin
               r0_q <= n2;
               r1_q <= n3;
               r2_q <= r0_q;
               r3_q <= r1_q;
               if (rnd_q == LAST_RND) begin
                  rnd_q       <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  rnd_q <= rnd_q + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
